parity_stream_unit: RTL and testbench

- Parametrised, clocked successor to the 3-input combinational parity generator.
- Accumulates even or odd parity over a multi-beat frame of WIDTH-bit words arriving on a valid/ready stream.
- Works in two modes: generate (emit the parity bit) or check (compare against a received parity bit and flag errors).
- Sits between a serial/link framing stage and its consumer. Holds one result until it is accepted downstream.

---
 rtl/parity_stream_unit.sv | 151 +++++++++++++++
 tb/tb_parity_stream_unit.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/parity_stream_unit.sv
// Frame parity generator/checker on a valid/ready stream.
// Accumulates parity over multi-beat frames and holds one result until it is accepted downstream.
module parity_stream_unit #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 8,
    parameter int unsigned ERR_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             mode,
    input  logic             odd_sel,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    input  logic             in_par,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_par,
    output logic             out_err,
    output logic [CNT_W-1:0] out_beats,
    input  logic             err_clr,
    output logic [ERR_W-1:0] err_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] BEATS_MAX = {CNT_W{1'b1}};
    localparam logic [ERR_W-1:0] ERR_MAX   = {ERR_W{1'b1}};

    state_t             state, state_d;
    logic               acc, acc_d;
    logic [CNT_W-1:0]   beats, beats_d;
    logic               mode_l, mode_l_d;
    logic               odd_l, odd_l_d;
    logic               out_valid_d, out_par_d, out_err_d;
    logic [CNT_W-1:0]   out_beats_d;
    logic [ERR_W-1:0]   err_count_d;

    logic               beat_acc;
    logic               acc_now, mode_now, odd_now, par_now;
    logic [CNT_W-1:0]   beats_now;

    assign beat_acc = in_valid && in_ready;

    // Running values including the beat on the current edge; the first beat restarts the frame.
    always_comb begin
        acc_now   = 1'b0;
        beats_now = '0;
        mode_now  = mode_l;
        odd_now   = odd_l;
        if (state == IDLE) begin
            acc_now   = ^in_data;
            beats_now = CNT_W'(1);
            mode_now  = mode;
            odd_now   = odd_sel;
        end else begin
            acc_now   = acc ^ (^in_data);
            beats_now = (beats == BEATS_MAX) ? beats : beats + CNT_W'(1);
        end
        par_now = acc_now ^ odd_now;
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d     = state;
        acc_d       = acc;
        beats_d     = beats;
        mode_l_d    = mode_l;
        odd_l_d     = odd_l;
        out_valid_d = out_valid;
        out_par_d   = out_par;
        out_err_d   = out_err;
        out_beats_d = out_beats;
        err_count_d = err_count;

        case (state)
            IDLE, ACC: begin
                if (beat_acc) begin
                    acc_d    = acc_now;
                    beats_d  = beats_now;
                    mode_l_d = mode_now;
                    odd_l_d  = odd_now;
                    state_d  = ACC;
                    if (in_last) begin
                        state_d     = HOLD;
                        out_valid_d = 1'b1;
                        out_par_d   = par_now;
                        out_err_d   = mode_now && (par_now != in_par);
                        out_beats_d = beats_now;
                        if (mode_now && (par_now != in_par) && (err_count != ERR_MAX)) begin
                            err_count_d = err_count + ERR_W'(1);
                        end
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                    acc_d       = 1'b0;
                    beats_d     = '0;
                end
            end
            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
                acc_d       = 1'b0;
                beats_d     = '0;
            end
        endcase

        // Clear wins over a coincident increment.
        if (err_clr) begin
            err_count_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            acc       <= 1'b0;
            beats     <= '0;
            mode_l    <= 1'b0;
            odd_l     <= 1'b0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            out_par   <= 1'b0;
            out_err   <= 1'b0;
            out_beats <= '0;
            err_count <= '0;
        end else begin
            state     <= state_d;
            acc       <= acc_d;
            beats     <= beats_d;
            mode_l    <= mode_l_d;
            odd_l     <= odd_l_d;
            out_valid <= out_valid_d;
            in_ready  <= !out_valid_d;
            out_par   <= out_par_d;
            out_err   <= out_err_d;
            out_beats <= out_beats_d;
            err_count <= err_count_d;
        end
    end

endmodule

// File: tb/tb_parity_stream_unit.sv
// Directed self-checking bench for parity_stream_unit (WIDTH=8, CNT_W=8, ERR_W=2).
module tb_parity_stream_unit;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned CNT_W = 8;
    localparam int unsigned ERR_W = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             mode, odd_sel;
    logic             in_valid, in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_last, in_par;
    logic             out_valid, out_ready;
    logic             out_par, out_err;
    logic [CNT_W-1:0] out_beats;
    logic             err_clr;
    logic [ERR_W-1:0] err_count;

    int total = 0;
    int bad   = 0;

    parity_stream_unit #(.WIDTH(WIDTH), .CNT_W(CNT_W), .ERR_W(ERR_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode      (mode),
        .odd_sel   (odd_sel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_par    (in_par),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_par   (out_par),
        .out_err   (out_err),
        .out_beats (out_beats),
        .err_clr   (err_clr),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present one beat and hold it until the edge that accepts it.
    task automatic send_beat(input logic [7:0] d, input logic last, input logic par);
        int n = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        in_par   = par;
        while (!in_ready && n < 20) begin
            step();
            n++;
        end
        if (!in_ready) begin
            total++;
            bad++;
            $error("FAIL ready_timeout observed=%0b expected=1", in_ready);
        end
        step();
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_par   = 1'b0;
    endtask

    task automatic take_result();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; mode = 1'b0; odd_sel = 1'b0; in_valid = 1'b0; in_data = '0;
        in_last = 1'b0; in_par = 1'b0; out_ready = 1'b0; err_clr = 1'b0;

        // Reset and idle
        repeat (3) step();
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_err_count", 32'(err_count), 32'd0);
        check("rst_out_beats", 32'(out_beats), 32'd0);

        // Generate, single beat 0xA5, even then odd
        send_beat(8'hA5, 1'b1, 1'b0);
        check("gen_even_valid", 32'(out_valid), 32'd1);
        check("gen_even_par", 32'(out_par), 32'd0);
        check("gen_even_err", 32'(out_err), 32'd0);
        check("gen_even_beats", 32'(out_beats), 32'd1);
        check("gen_even_in_ready", 32'(in_ready), 32'd0);
        take_result();
        check("gen_even_released", 32'(out_valid), 32'd0);
        odd_sel = 1'b1;
        send_beat(8'hA5, 1'b1, 1'b0);
        check("gen_odd_par", 32'(out_par), 32'd1);
        take_result();

        // Check mode, 0x01 0x03 0x07 with wrong then right parity
        mode = 1'b1; odd_sel = 1'b0;
        send_beat(8'h01, 1'b0, 1'b0);
        check("chk_mid_valid", 32'(out_valid), 32'd0);
        send_beat(8'h03, 1'b0, 1'b0);
        send_beat(8'h07, 1'b1, 1'b1);
        check("chk_bad_par", 32'(out_par), 32'd0);
        check("chk_bad_err", 32'(out_err), 32'd1);
        check("chk_bad_beats", 32'(out_beats), 32'd3);
        check("chk_bad_cnt", 32'(err_count), 32'd1);
        take_result();
        send_beat(8'h01, 1'b0, 1'b0);
        send_beat(8'h03, 1'b0, 1'b0);
        send_beat(8'h07, 1'b1, 1'b0);
        check("chk_ok_err", 32'(out_err), 32'd0);
        check("chk_ok_cnt", 32'(err_count), 32'd1);
        take_result();

        // Backpressure with a waiting beat
        mode = 1'b0; odd_sel = 1'b0;
        send_beat(8'h0F, 1'b1, 1'b0);
        in_valid = 1'b1; in_data = 8'h01; in_last = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_valid", 32'(out_valid), 32'd1);
            check("bp_par", 32'(out_par), 32'd0);
            check("bp_beats", 32'(out_beats), 32'd1);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("bp_hs_valid", 32'(out_valid), 32'd0);
        check("bp_hs_in_ready", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0; in_last = 1'b0;
        check("bp_next_valid", 32'(out_valid), 32'd1);
        check("bp_next_par", 32'(out_par), 32'd1);
        take_result();

        // Reset in the middle of a frame
        send_beat(8'h01, 1'b0, 1'b0);
        send_beat(8'h02, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        check("mrst_valid", 32'(out_valid), 32'd0);
        check("mrst_in_ready", 32'(in_ready), 32'd1);
        check("mrst_beats", 32'(out_beats), 32'd0);
        check("mrst_par", 32'(out_par), 32'd0);
        check("mrst_cnt", 32'(err_count), 32'd0);
        step();
        @(negedge clk);
        rst_n = 1'b1;
        step();
        send_beat(8'h80, 1'b1, 1'b0);
        check("mrst_new_par", 32'(out_par), 32'd1);
        check("mrst_new_beats", 32'(out_beats), 32'd1);
        take_result();

        // Error counter saturation at 3, then clear over an increment
        mode = 1'b1; odd_sel = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            send_beat(8'h00, 1'b1, 1'b1);
            check("sat_err", 32'(out_err), 32'd1);
            check("sat_cnt", 32'(err_count), (i > 3) ? 32'd3 : 32'(i));
            take_result();
        end
        err_clr = 1'b1;
        send_beat(8'h00, 1'b1, 1'b1);
        err_clr = 1'b0;
        check("clr_err", 32'(out_err), 32'd1);
        check("clr_cnt", 32'(err_count), 32'd0);
        take_result();

        // Mode and odd_sel changes after the first beat are ignored
        mode = 1'b1; odd_sel = 1'b0;
        send_beat(8'h03, 1'b0, 1'b0);
        mode = 1'b0; odd_sel = 1'b1;
        send_beat(8'h01, 1'b1, 1'b0);
        check("latch_par", 32'(out_par), 32'd1);
        check("latch_err", 32'(out_err), 32'd1);
        check("latch_cnt", 32'(err_count), 32'd1);
        take_result();

        // Beat counter saturates at 255 over a 300-beat frame
        mode = 1'b0; odd_sel = 1'b0;
        for (int i = 0; i < 300; i++) begin
            send_beat(8'h01, (i == 299) ? 1'b1 : 1'b0, 1'b0);
        end
        check("long_beats", 32'(out_beats), 32'd255);
        check("long_par", 32'(out_par), 32'd0);
        take_result();

        // out_ready with nothing pending
        out_ready = 1'b1;
        step();
        step();
        out_ready = 1'b0;
        check("idle_rdy_valid", 32'(out_valid), 32'd0);
        check("idle_rdy_in_ready", 32'(in_ready), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
